// File: rtl/mod14_counter_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mod14_counter_sequencer_pkg
// Shared definitions for the mod-14 counter command sequencer:
//   - command opcode encoding (OP_CLEAR / OP_LOAD / OP_UP / OP_DOWN)
//   - controller state encoding (ST_INIT / ST_IDLE / ST_EXEC)
//   - MOD_MAX, the highest value the external counter can hold
//   - small decode helpers used by the top level
// -----------------------------------------------------------------------------
package mod14_counter_sequencer_pkg;

  // Highest legal counter value (counter wraps 13 -> 0 and 0 -> 13).
  localparam int MOD_MAX = 13;

  // Command opcodes as seen on req_op.
  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  // Controller states; the unused encoding 2'b11 recovers to ST_INIT.
  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_EXEC = 2'b10
  } state_e;

  // True for the multi-cycle stepping opcodes.
  function automatic logic is_step_op(input logic [1:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

  // True for a LOAD whose value the counter cannot represent.
  function automatic logic is_bad_load(input logic [1:0] op,
                                       input logic [3:0] data,
                                       input logic [3:0] max_val);
    return (op == OP_LOAD) && (data > max_val);
  endfunction

endpackage

// File: rtl/mod14_counter_sequencer_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter. A lone valid requester always wins; when both
// are valid the pointer picks the winner. The pointer moves to the other
// requester whenever a grant is actually taken (accept).
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous active-low reset (pointer -> 0)
//   enable  in   grants may be issued (controller idle)
//   req     in   [1:0] request valid, one bit per requester
//   accept  in   the current grant was transferred this cycle
//   gnt     out  [1:0] one-hot grant (all zero when disabled or no request)
//   gnt_id  out  index of the requester that would be granted
// -----------------------------------------------------------------------------
module rr_arbiter2
  import mod14_counter_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q;
  logic ptr_d;
  logic gnt_id_s;

  // Winner selection: a single requester wins outright, a tie goes to ptr_q.
  always_comb begin
    gnt_id_s = 1'b0;
    case (req)
      2'b01:   gnt_id_s = 1'b0;
      2'b10:   gnt_id_s = 1'b1;
      2'b11:   gnt_id_s = ptr_q;
      default: gnt_id_s = 1'b0;
    endcase
  end

  // One-hot grant, only while enabled and something is requesting.
  always_comb begin
    gnt = 2'b00;
    if (enable && (req != 2'b00)) begin
      gnt = gnt_id_s ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
  end

  // After a transfer the other requester gets priority on the next tie.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ~gnt_id_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_id = gnt_id_s;

endmodule

// File: rtl/mod14_counter_sequencer.sv
// -----------------------------------------------------------------------------
// mod14_counter_sequencer
// Command controller for one external mod-14 loadable up/down counter that has
// no enable input. Two requesters share it through valid/ready ports with
// round-robin arbitration. While idle the counter is frozen by reloading its
// own value every cycle.
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-low reset
//   req_valid    in   [1:0] command valid per requester
//   req_ready    out  [1:0] command accept (at most one bit high, idle only)
//   req_op       in   [1:0][1:0] opcode per requester (CLEAR/LOAD/UP/DOWN)
//   req_data     in   [1:0][3:0] LOAD value per requester
//   req_steps    in   [1:0][STEP_W-1:0] step count per requester
//   cnt_reset    out  synchronous clear to the counter
//   cnt_load     out  counter load strobe
//   cnt_up_down  out  counter direction, 1 = up
//   cnt_data     out  [3:0] counter load data
//   cnt_value    in   [3:0] counter current value
//   busy         out  command executing
//   done         out  one-cycle completion pulse
//   done_id      out  requester index of the completed command
//   err          out  one-cycle pulse alongside done for a rejected command
// -----------------------------------------------------------------------------
module mod14_counter_sequencer #(
  parameter int STEP_W  = 8,
  parameter int MOD_MAX = mod14_counter_sequencer_pkg::MOD_MAX
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][1:0]        req_op,
  input  logic [1:0][3:0]        req_data,
  input  logic [1:0][STEP_W-1:0] req_steps,
  output logic                   cnt_reset,
  output logic                   cnt_load,
  output logic                   cnt_up_down,
  output logic [3:0]             cnt_data,
  input  logic [3:0]             cnt_value,
  output logic                   busy,
  output logic                   done,
  output logic                   done_id,
  output logic                   err
);

  import mod14_counter_sequencer_pkg::*;

  localparam logic [3:0]        MAX_VAL  = 4'(MOD_MAX);
  localparam logic [STEP_W-1:0] ONE_STEP = STEP_W'(1);

  // State and latched command.
  state_e            state_q,   state_d;
  logic [1:0]        op_q,      op_d;
  logic [3:0]        data_q,    data_d;
  logic [STEP_W-1:0] rem_q,     rem_d;
  logic              id_q,      id_d;

  // Registered status outputs.
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              done_id_q, done_id_d;
  logic              err_q,     err_d;

  // Arbitration and the command currently offered by the grant winner.
  logic              arb_en_s;
  logic [1:0]        gnt_s;
  logic              gnt_id_s;
  logic              accept_s;
  logic [1:0]        sel_op_s;
  logic [3:0]        sel_data_s;
  logic [STEP_W-1:0] sel_steps_s;
  logic              sel_bad_s;
  logic              sel_zero_s;

  assign arb_en_s = (state_q == ST_IDLE);
  assign accept_s = |(req_valid & gnt_s);

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_en_s),
    .req    (req_valid),
    .accept (accept_s),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  assign req_ready = gnt_s;

  // Decode the command offered by the currently selected requester.
  always_comb begin
    sel_op_s    = req_op[gnt_id_s];
    sel_data_s  = req_data[gnt_id_s];
    sel_steps_s = req_steps[gnt_id_s];
    sel_bad_s   = is_bad_load(sel_op_s, sel_data_s, MAX_VAL);
    sel_zero_s  = is_step_op(sel_op_s) && (sel_steps_s == '0);
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // Rejected and zero-length commands complete without an EXEC cycle.
        if (accept_s && !sel_bad_s && !sel_zero_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (rem_q <= ONE_STEP) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Command latch, step down-counter and completion status.
  always_comb begin
    op_d      = op_q;
    data_d    = data_q;
    rem_d     = rem_q;
    id_d      = id_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d   = sel_op_s;
          data_d = sel_data_s;
          id_d   = gnt_id_s;
          // CLEAR and LOAD take exactly one execution cycle.
          rem_d  = is_step_op(sel_op_s) ? sel_steps_s : ONE_STEP;
          if (sel_bad_s || sel_zero_s) begin
            done_d    = 1'b1;
            err_d     = sel_bad_s;
            done_id_d = gnt_id_s;
          end else begin
            done_d    = 1'b0;
            err_d     = 1'b0;
            done_id_d = done_id_q;
          end
        end else begin
          rem_d = rem_q;
        end
      end
      ST_EXEC: begin
        if (rem_q <= ONE_STEP) begin
          rem_d     = '0;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          rem_d = rem_q - ONE_STEP;
        end
      end
      ST_INIT: begin
        rem_d = '0;
      end
      default: begin
        rem_d = '0;
      end
    endcase
    busy_d = (state_d == ST_EXEC);
  end

  // Datapath and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_CLEAR;
      data_q    <= 4'd0;
      rem_q     <= '0;
      id_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      op_q      <= op_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      err_q     <= err_d;
    end
  end

  // Counter control, decoded from the registered state and latched command.
  always_comb begin
    cnt_reset   = 1'b0;
    cnt_load    = 1'b0;
    cnt_up_down = 1'b0;
    cnt_data    = 4'd0;
    case (state_q)
      ST_INIT: begin
        cnt_reset = 1'b1;
      end
      ST_IDLE: begin
        // The counter has no enable, so reload its own value to freeze it.
        cnt_load = 1'b1;
        cnt_data = cnt_value;
      end
      ST_EXEC: begin
        case (op_q)
          OP_CLEAR: cnt_reset   = 1'b1;
          OP_LOAD: begin
            cnt_load = 1'b1;
            cnt_data = data_q;
          end
          OP_UP:    cnt_up_down = 1'b1;
          OP_DOWN:  cnt_up_down = 1'b0;
          default:  cnt_reset   = 1'b1;
        endcase
      end
      default: begin
        cnt_reset = 1'b1;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mod14_counter_sequencer.sv
// Directed bench for mod14_counter_sequencer with a behavioural mod-14 counter.
module tb_mod14_counter_sequencer;
  localparam int STEP_W = 8;
  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_LOAD  = 2'b01;
  localparam logic [1:0] C_UP    = 2'b10;
  localparam logic [1:0] C_DOWN  = 2'b11;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0]             req_valid = 2'b00;
  logic [1:0]             req_ready;
  logic [1:0][1:0]        req_op;
  logic [1:0][3:0]        req_data;
  logic [1:0][STEP_W-1:0] req_steps;
  logic cnt_reset, cnt_load, cnt_up_down;
  logic [3:0] cnt_data;
  logic [3:0] cnt_value = 4'd9;
  logic busy, done, done_id, err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  // External counter: no enable, counts every clock unless reset or loading.
  always @(posedge clock) begin
    if (cnt_reset) cnt_value <= 4'd0;
    else if (cnt_load) cnt_value <= cnt_data;
    else if (cnt_up_down) cnt_value <= (cnt_value == 4'd13) ? 4'd0 : cnt_value + 4'd1;
    else cnt_value <= (cnt_value == 4'd0) ? 4'd13 : cnt_value - 4'd1;
  end

  mod14_counter_sequencer #(.STEP_W(STEP_W), .MOD_MAX(13)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_steps(req_steps),
    .cnt_reset(cnt_reset), .cnt_load(cnt_load), .cnt_up_down(cnt_up_down),
    .cnt_data(cnt_data), .cnt_value(cnt_value),
    .busy(busy), .done(done), .done_id(done_id), .err(err)
  );

  // Offer one command and return #1 after the edge that accepts it.
  task automatic send(input int id, input logic [1:0] op, input logic [3:0] data,
                      input logic [STEP_W-1:0] steps, input string name);
    bit ok;
    ok = 1'b0;
    req_op[id] = op; req_data[id] = data; req_steps[id] = steps;
    req_valid[id] = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clock);
      if (req_ready[id]) ok = 1'b1;
    end
    @(posedge clock); #1;
    req_valid[id] = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL %s_grant: ready=0 for requester %0d, required 1", name, id); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rst_ready: got %b want 00", req_ready); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || done_id !== 1'b0) begin
      miscompares++; $display("FAIL rst_status: busy=%b done=%b err=%b id=%b want 0000", busy, done, err, done_id); end
    vectors++; if (cnt_reset !== 1'b1) begin miscompares++; $display("FAIL rst_cnt_reset: got %b want 1", cnt_reset); end
    @(negedge clock); reset = 1'b1; #1;
    vectors++; if (cnt_reset !== 1'b1) begin miscompares++; $display("FAIL init_cnt_reset: got %b want 1", cnt_reset); end
    @(posedge clock); #1;
    vectors++; if (cnt_reset !== 1'b0 || cnt_load !== 1'b1) begin
      miscompares++; $display("FAIL idle_ctrl: reset=%b load=%b want 0 1", cnt_reset, cnt_load); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (cnt_value !== 4'd0 || req_ready !== 2'b00) begin
        miscompares++; $display("FAIL idle_hold: value=%0d ready=%b want 0 00", cnt_value, req_ready); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_load_up();
    logic [3:0] exp_seq [3] = '{4'd13, 4'd0, 4'd1};
    send(0, C_LOAD, 4'd12, 8'd0, "load12");
    vectors++; if (busy !== 1'b1 || cnt_load !== 1'b1 || cnt_data !== 4'd12 || req_ready !== 2'b00) begin
      miscompares++; $display("FAIL load12_exec: busy=%b load=%b data=%0d ready=%b want 1 1 12 00", busy, cnt_load, cnt_data, req_ready); end
    @(posedge clock); #1;
    vectors++; if (cnt_value !== 4'd12 || done !== 1'b1 || done_id !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL load12_done: value=%0d done=%b id=%b err=%b busy=%b want 12 1 0 0 0", cnt_value, done, done_id, err, busy); end
    send(0, C_UP, 4'd0, 8'd3, "up3");
    vectors++; if (busy !== 1'b1 || cnt_up_down !== 1'b1 || cnt_load !== 1'b0 || cnt_reset !== 1'b0) begin
      miscompares++; $display("FAIL up3_exec: busy=%b dir=%b load=%b rst=%b want 1 1 0 0", busy, cnt_up_down, cnt_load, cnt_reset); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      vectors++; if (cnt_value !== exp_seq[k] || done !== (k == 2)) begin
        miscompares++; $display("FAIL up3_step%0d: value=%0d done=%b want %0d %b", k, cnt_value, done, exp_seq[k], k == 2); end
    end
    vectors++; if (done_id !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL up3_done: id=%b busy=%b err=%b want 0 0 0", done_id, busy, err); end
    repeat (3) begin
      @(posedge clock); #1;
      vectors++; if (cnt_value !== 4'd1 || done !== 1'b0) begin
        miscompares++; $display("FAIL up3_hold: value=%0d done=%b want 1 0", cnt_value, done); end
    end
  endtask

  task automatic test_load_down();
    logic [3:0] exp_seq [3] = '{4'd0, 4'd13, 4'd12};
    send(1, C_LOAD, 4'd1, 8'd0, "load1");
    @(posedge clock); #1;
    vectors++; if (cnt_value !== 4'd1 || done !== 1'b1 || done_id !== 1'b1) begin
      miscompares++; $display("FAIL load1_done: value=%0d done=%b id=%b want 1 1 1", cnt_value, done, done_id); end
    send(1, C_DOWN, 4'd0, 8'd3, "down3");
    vectors++; if (busy !== 1'b1 || cnt_up_down !== 1'b0 || cnt_load !== 1'b0) begin
      miscompares++; $display("FAIL down3_exec: busy=%b dir=%b load=%b want 1 0 0", busy, cnt_up_down, cnt_load); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      vectors++; if (cnt_value !== exp_seq[k] || done !== (k == 2)) begin
        miscompares++; $display("FAIL down3_step%0d: value=%0d done=%b want %0d %b", k, cnt_value, done, exp_seq[k], k == 2); end
    end
    vectors++; if (done_id !== 1'b1 || err !== 1'b0) begin
      miscompares++; $display("FAIL down3_done: id=%b err=%b want 1 0", done_id, err); end
    repeat (2) @(posedge clock);
    #1;
    vectors++; if (cnt_value !== 4'd12) begin miscompares++; $display("FAIL down3_hold: value=%0d want 12", cnt_value); end
  endtask

  task automatic test_illegal();
    send(0, C_LOAD, 4'd14, 8'd0, "load14");
    vectors++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || done_id !== 1'b0 || cnt_value !== 4'd12 || cnt_data !== 4'd12) begin
      miscompares++; $display("FAIL load14: done=%b err=%b busy=%b id=%b value=%0d data=%0d want 1 1 0 0 12 12", done, err, busy, done_id, cnt_value, cnt_data); end
    @(posedge clock); #1;
    vectors++; if (done !== 1'b0 || err !== 1'b0 || cnt_value !== 4'd12) begin
      miscompares++; $display("FAIL load14_after: done=%b err=%b value=%0d want 0 0 12", done, err, cnt_value); end
    send(0, C_UP, 4'd0, 8'd0, "up0");
    vectors++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || cnt_value !== 4'd12) begin
      miscompares++; $display("FAIL up0: done=%b err=%b busy=%b value=%0d want 1 0 0 12", done, err, busy, cnt_value); end
    send(1, C_CLEAR, 4'd0, 8'd0, "clear");
    vectors++; if (busy !== 1'b1 || cnt_reset !== 1'b1) begin
      miscompares++; $display("FAIL clear_exec: busy=%b rst=%b want 1 1", busy, cnt_reset); end
    @(posedge clock); #1;
    vectors++; if (cnt_value !== 4'd0 || done !== 1'b1 || done_id !== 1'b1 || err !== 1'b0) begin
      miscompares++; $display("FAIL clear_done: value=%0d done=%b id=%b err=%b want 0 1 1 0", cnt_value, done, done_id, err); end
  endtask

  task automatic test_mid_reset();
    int seen_done;
    seen_done = 0;
    send(0, C_UP, 4'd0, 8'd10, "up10");
    repeat (4) @(posedge clock);
    #1;
    vectors++; if (cnt_value !== 4'd4) begin miscompares++; $display("FAIL up10_partial: value=%0d want 4", cnt_value); end
    reset = 1'b0; #1;
    vectors++; if (busy !== 1'b0 || cnt_reset !== 1'b1 || req_ready !== 2'b00) begin
      miscompares++; $display("FAIL abort: busy=%b rst=%b ready=%b want 0 1 00", busy, cnt_reset, req_ready); end
    repeat (2) begin @(posedge clock); #1; if (done) seen_done++; end
    @(negedge clock); reset = 1'b1;
    repeat (3) begin @(posedge clock); #1; if (done) seen_done++; end
    vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL abort_done: %0d pulses want 0", seen_done); end
    vectors++; if (cnt_value !== 4'd0) begin miscompares++; $display("FAIL abort_clear: value=%0d want 0", cnt_value); end
    send(1, C_LOAD, 4'd5, 8'd0, "load5");
    @(posedge clock); #1;
    vectors++; if (cnt_value !== 4'd5 || done !== 1'b1 || done_id !== 1'b1) begin
      miscompares++; $display("FAIL load5_done: value=%0d done=%b id=%b want 5 1 1", cnt_value, done, done_id); end
  endtask

  task automatic test_back_to_back();
    int exp_g [4] = '{0, 1, 0, 1};
    int g [4] = '{-1, -1, -1, -1};
    int ng, ready_busy, multi;
    ng = 0; ready_busy = 0; multi = 0;
    req_op[0] = C_LOAD; req_data[0] = 4'd3; req_steps[0] = 8'd0;
    req_op[1] = C_LOAD; req_data[1] = 4'd7; req_steps[1] = 8'd0;
    req_valid = 2'b11;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clock);
      if (busy && req_ready != 2'b00) ready_busy++;
      if (req_ready == 2'b11) multi++;
      if (req_ready == 2'b01) begin g[ng] = 0; ng++; end
      else if (req_ready == 2'b10) begin g[ng] = 1; ng++; end
    end
    @(posedge clock); #1;
    req_valid = 2'b00;
    vectors++; if (ng !== 4) begin miscompares++; $display("FAIL rr_count: %0d grants want 4", ng); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (g[k] !== exp_g[k]) begin miscompares++; $display("FAIL rr_grant%0d: got %0d want %0d", k, g[k], exp_g[k]); end
    end
    vectors++; if (ready_busy !== 0 || multi !== 0) begin
      miscompares++; $display("FAIL rr_ready: busy-ready=%0d both-ready=%0d want 0 0", ready_busy, multi); end
    @(posedge clock); #1;
    vectors++; if (cnt_value !== 4'd7 || done !== 1'b1 || done_id !== 1'b1) begin
      miscompares++; $display("FAIL rr_last: value=%0d done=%b id=%b want 7 1 1", cnt_value, done, done_id); end
  endtask

  initial begin
    req_op = '0; req_data = '0; req_steps = '0;
    test_reset();
    test_load_up();
    test_load_down();
    test_illegal();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
